mem_write_checker: RTL and testbench

Synthesizable store-stream checker for the single-cycle RISC-V core's data-memory write port (MemWrite/DataAddr/WriteData). It watches writes against a loadable table of NUM_EXP expected (address, data) pairs in order, tolerates writes to a programmable ignore address, and flags pass, mismatch or timeout. Used in benches and on FPGA as a hardware self-check in place of per-program procedural checks.

---
 rtl/mwc_pkg.sv | 12 +
 rtl/mwc_timeout_counter.sv | 18 +
 rtl/mem_write_checker.sv | 136 +++++++++++++
 tb/tb_mem_write_checker.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mwc_pkg.sv
// mwc_pkg: shared state encoding and failure codes for the memory write checker
package mwc_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_PASS  = 2'd2,
        S_FAIL  = 2'd3
    } state_t;
    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_MISMATCH = 2'd1;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd2;
endpackage

// File: rtl/mwc_timeout_counter.sv
// mwc_timeout_counter: counts idle armed cycles, expired when TIMEOUT-1 is reached
module mwc_timeout_counter #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
    assign expired_o = cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/mem_write_checker.sv
// mem_write_checker: checks a store stream against an ordered table of expected writes
module mem_write_checker
    import mwc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_EXP = 4,
    parameter int TIMEOUT = 1024,
    localparam int IDX_W  = NUM_EXP > 1 ? $clog2(NUM_EXP) : 1,
    localparam int NA_W   = $clog2(NUM_EXP) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tbl_we,
    input  logic [IDX_W-1:0]  tbl_idx,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_data,
    input  logic [NA_W-1:0]   num_active,
    input  logic              ign_en,
    input  logic [ADDR_W-1:0] ign_addr,
    input  logic              start,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] DataAddr,
    input  logic [DATA_W-1:0] WriteData,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data,
    output logic [NA_W-1:0]   match_count,
    output logic [15:0]       ign_count
);
    state_t state_q, state_d;
    logic [ADDR_W-1:0] taddr_q [NUM_EXP];
    logic [DATA_W-1:0] tdata_q [NUM_EXP];
    logic [ADDR_W-1:0] cur_addr, faddr_q, faddr_d;
    logic [DATA_W-1:0] cur_data, fdata_q, fdata_d;
    logic [NA_W-1:0]   mc_q, mc_d, na_q, na_d;
    logic [15:0]       ign_q, ign_d;
    logic [1:0]        fcode_q, fcode_d;
    logic              armed, hit, t_clr, t_en, t_exp;
    assign armed = state_q == S_ARMED;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                taddr_q[i] <= '0;
                tdata_q[i] <= '0;
            end
        end else if (tbl_we && !armed) begin
            for (int i = 0; i < NUM_EXP; i++)
                if (tbl_idx == IDX_W'(i)) begin
                    taddr_q[i] <= tbl_addr;
                    tdata_q[i] <= tbl_data;
                end
        end
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < NUM_EXP; i++)
            if (mc_q == NA_W'(i)) begin
                cur_addr = taddr_q[i];
                cur_data = tdata_q[i];
            end
    end
    always_comb begin
        state_d = state_q;
        mc_d    = mc_q;
        na_d    = na_q;
        ign_d   = ign_q;
        fcode_d = fcode_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;
        hit     = armed && MemWrite && DataAddr == cur_addr && WriteData == cur_data;
        t_clr   = hit;
        t_en    = armed && !hit;
        if (!armed && start) begin
            state_d = S_ARMED;
            mc_d    = '0;
            na_d    = (num_active == '0 || num_active > NA_W'(NUM_EXP)) ? NA_W'(NUM_EXP) : num_active;
            ign_d   = '0;
            fcode_d = FAIL_NONE;
            faddr_d = '0;
            fdata_d = '0;
            t_clr   = 1'b1;
        end else if (hit) begin
            mc_d    = mc_q + NA_W'(1);
            state_d = mc_d == na_q ? S_PASS : S_ARMED;
        end else if (armed && MemWrite && !(ign_en && DataAddr == ign_addr)) begin
            state_d = S_FAIL;
            fcode_d = FAIL_MISMATCH;
            faddr_d = DataAddr;
            fdata_d = WriteData;
        end else if (armed) begin
            // tolerated writes do not hold off the timeout
            ign_d = (MemWrite && ign_q != 16'hFFFF) ? ign_q + 16'd1 : ign_q;
            if (t_exp) begin
                state_d = S_FAIL;
                fcode_d = FAIL_TIMEOUT;
            end
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= S_IDLE;
            mc_q    <= '0;
            na_q    <= '0;
            ign_q   <= '0;
            fcode_q <= FAIL_NONE;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            mc_q    <= mc_d;
            na_q    <= na_d;
            ign_q   <= ign_d;
            fcode_q <= fcode_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    mwc_timeout_counter #(.TIMEOUT(TIMEOUT)) u_to (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (t_clr),
        .en_i     (t_en),
        .expired_o(t_exp)
    );
    assign busy        = armed;
    assign pass        = state_q == S_PASS;
    assign fail        = state_q == S_FAIL;
    assign fail_code   = fcode_q;
    assign fail_addr   = faddr_q;
    assign fail_data   = fdata_q;
    assign match_count = mc_q;
    assign ign_count   = ign_q;
endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: scoreboard bench for the store-stream checker
module tb_mem_write_checker;
    typedef struct packed {
        logic        p;
        logic        f;
        logic [1:0]  code;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  mc;
        logic [15:0] ign;
    } res_t;
    logic        clk = 1'b0, reset = 1'b1;
    logic        tbl_we = 1'b0, ign_en = 1'b0, start = 1'b0, MemWrite = 1'b0;
    logic [1:0]  tbl_idx = '0;
    logic [31:0] tbl_addr = '0, tbl_data = '0, ign_addr = '0, DataAddr = '0, WriteData = '0;
    logic [2:0]  num_active = '0;
    logic        busy, pass, fail;
    logic [1:0]  fail_code;
    logic [31:0] fail_addr, fail_data;
    logic [2:0]  match_count;
    logic [15:0] ign_count;
    int n_chk = 0, n_err = 0;
    res_t sb[$];
    always #5 clk = ~clk;
    mem_write_checker #(.ADDR_W(32), .DATA_W(32), .NUM_EXP(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_addr(tbl_addr),
        .tbl_data(tbl_data), .num_active(num_active), .ign_en(ign_en), .ign_addr(ign_addr),
        .start(start), .MemWrite(MemWrite), .DataAddr(DataAddr), .WriteData(WriteData),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code), .fail_addr(fail_addr),
        .fail_data(fail_data), .match_count(match_count), .ign_count(ign_count)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
        tbl_we = 1'b1; tbl_idx = idx; tbl_addr = a; tbl_data = d;
        @(negedge clk);
        tbl_we = 1'b0;
    endtask
    task automatic arm(input logic [2:0] n);
        num_active = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite = 1'b1; DataAddr = a; WriteData = d;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask
    task automatic expect_res(input logic p, input logic f, input logic [1:0] code, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] mc, input logic [15:0] ign);
        res_t r;
        r.p = p; r.f = f; r.code = code; r.a = a; r.d = d; r.mc = mc; r.ign = ign;
        sb.push_back(r);
    endtask
    task automatic finish_run(input string tag);
        res_t e;
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".busy"}, busy, 0);
        check({tag, ".sb"}, sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, ".pass"}, pass, e.p);
        check({tag, ".fail"}, fail, e.f);
        check({tag, ".code"}, fail_code, e.code);
        check({tag, ".faddr"}, fail_addr, e.a);
        check({tag, ".fdata"}, fail_data, e.d);
        check({tag, ".mc"}, match_count, e.mc);
        check({tag, ".ign"}, ign_count, e.ign);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge clk);
        check("rst.busy", busy, 0);
        check("rst.pass", pass, 0);
        check("rst.fail", fail, 0);
        check("rst.code", fail_code, 0);
        check("rst.mc", match_count, 0);
        check("rst.ign", ign_count, 0);
        reset = 1'b0;
        @(negedge clk);
        load(0, 100, 25);
        load(1, 200, 50);
        ign_en = 1'b1; ign_addr = 96;
        arm(1);
        check("s1.armed", busy, 1);
        wr(96, 7); wr(96, 9); wr(100, 25);
        expect_res(1, 0, 0, 0, 0, 1, 2);
        finish_run("s1");
        arm(1);
        wr(104, 25);
        expect_res(0, 1, 1, 104, 25, 0, 0);
        finish_run("s2");
        wr(100, 25);
        expect_res(0, 1, 1, 104, 25, 0, 0);
        finish_run("s2.sticky");
        arm(1);
        wr(100, 26);
        expect_res(0, 1, 1, 100, 26, 0, 0);
        finish_run("s2.data");
        arm(1);
        repeat (15) @(negedge clk);
        check("to.busy15", busy, 1);
        @(negedge clk);
        check("to.fail16", fail, 1);
        expect_res(0, 1, 2, 0, 0, 0, 0);
        finish_run("to");
        arm(2);
        repeat (14) @(negedge clk);
        wr(100, 25);
        check("to2.mc", match_count, 1);
        repeat (15) @(negedge clk);
        check("to2.busy", busy, 1);
        @(negedge clk);
        check("to2.fail", fail, 1);
        expect_res(0, 1, 2, 0, 0, 1, 0);
        finish_run("to2");
        arm(2);
        repeat (15) @(negedge clk);
        wr(100, 25);
        check("to3.edge_match", busy, 1);
        wr(200, 50);
        expect_res(1, 0, 0, 0, 0, 2, 0);
        finish_run("to3");
        load(0, 'h10, 1); load(1, 'h14, 2); load(2, 'h18, 3); load(3, 'h1C, 4);
        arm(3);
        wr('h14, 2);
        expect_res(0, 1, 1, 'h14, 2, 0, 0);
        finish_run("s4.order");
        arm(3);
        wr('h10, 1); wr('h14, 2); wr('h18, 3);
        expect_res(1, 0, 0, 0, 0, 3, 0);
        finish_run("s4.pass");
        arm(0);
        wr('h10, 1); wr('h14, 2); wr('h18, 3);
        check("na0.busy", busy, 1);
        wr('h1C, 4);
        expect_res(1, 0, 0, 0, 0, 4, 0);
        finish_run("na0");
        arm(3);
        wr('h10, 1);
        check("s5.mc", match_count, 1);
        reset = 1'b1;
        #1;
        check("s5.busy", busy, 0);
        check("s5.mc0", match_count, 0);
        check("s5.pass", pass, 0);
        check("s5.fail", fail, 0);
        @(negedge clk);
        reset = 1'b0;
        arm(1);
        wr('h10, 1);
        expect_res(0, 1, 1, 'h10, 1, 0, 0);
        finish_run("s5.cleared");
        load(0, 'h10, 1); load(1, 'h14, 2); load(2, 'h18, 3);
        num_active = 3; start = 1'b1; MemWrite = 1'b1; DataAddr = 'h44; WriteData = 4;
        @(negedge clk);
        start = 1'b0; MemWrite = 1'b0;
        check("s5.startwr", busy, 1);
        wr('h10, 1); wr('h14, 2); wr('h18, 3);
        expect_res(1, 0, 0, 0, 0, 3, 0);
        finish_run("s5.rerun");
        arm(3);
        load(0, 'h99, 9);
        wr('h10, 1);
        num_active = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr('h14, 2); wr('h18, 3);
        expect_res(1, 0, 0, 0, 0, 3, 0);
        finish_run("s6");
        arm(3);
        check("s6.rearm_mc", match_count, 0);
        check("s6.rearm_pass", pass, 0);
        wr('h10, 1); wr('h14, 2); wr('h18, 3);
        expect_res(1, 0, 0, 0, 0, 3, 0);
        finish_run("s6.second");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
